onehot_display_driver: RTL and testbench
========================================

ONEHOT_DISPLAY_DRIVER -- requirements
Module: onehot_display_driver

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 4, clock cycles each digit stays selected (legal 2..1024).
REQ-002 SHALL provide parameter SEG_ACTIVE_LOW, default 1, 1 = SEG/DIG driven active-low, 0 = active-high.
REQ-003 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port UNITS_OH  input  10  one-hot units digit from upstream decade counter, synchronous to CLK.
REQ-006 SHALL have port TENS_OH  input  10  one-hot tens digit from upstream mod-6 counter, synchronous to CLK.
REQ-007 SHALL have port BCD_UNITS  output  4  registered BCD of last valid UNITS_OH.
REQ-008 SHALL have port BCD_TENS  output  4  registered BCD of last valid TENS_OH.
REQ-009 SHALL have port CARRY  output  1  one-cycle pulse on units wrap 9->0.
REQ-010 SHALL have port WRAP  output  1  one-cycle pulse on tens wrap 5->0 or 9->0.
REQ-011 SHALL have port ERR  output  1  registered flag, input not one-hot.
REQ-012 SHALL have port SEG  output  7  segments {g,f,e,d,c,b,a} of selected digit.
REQ-013 SHALL have port DIG  output  2  digit select, bit0 = units, bit1 = tens.

Function
REQ-014 SHALL sample both inputs every rising edge; a one-hot input with bit n set SHALL load BCD n into its BCD register at that edge (latency 1 cycle).
REQ-015 SHALL treat an input with zero or more than one bit set as invalid: its BCD register holds, ERR = 1 for that cycle, else ERR = 0.
REQ-016 SHALL assert CARRY for exactly one cycle, registered at the edge where stored units one-hot is bit9 and UNITS_OH is bit0 (same cycle BCD_UNITS becomes 0).
REQ-017 SHALL assert WRAP for exactly one cycle, registered at the edge where stored tens one-hot is bit5 or bit9 and TENS_OH is bit0.
REQ-018 SHALL compare edges against the last valid stored value; an invalid sample SHALL generate no CARRY/WRAP and SHALL not alter stored value.
REQ-019 SHALL generate no CARRY/WRAP for other transitions (skips, backwards, 0->0 hold).
REQ-020 SHALL generate CARRY and WRAP independently; both may pulse in the same cycle.
REQ-021 SHALL run a scan counter 0..SCAN_DIV-1; at terminal count it wraps to 0 and DIG toggles units<->tens.
REQ-022 SHALL decode SEG combinationally from registered BCD of the digit DIG selects, standard 7-seg for 0..9 (0 = a-f, 1 = b,c, 7 = a,b,c, 8 = all).
REQ-023 SHALL show dash (g only) on SEG, both digits, while ERR = 1.
REQ-024 SHALL invert SEG and DIG polarity at output when SEG_ACTIVE_LOW = 1; internal logic unaffected.
REQ-025 SHALL keep exactly one DIG bit active at all times outside reset.

Reset
REQ-026 SHALL on RESET = 1, immediately and regardless of CLK: stored one-hots = bit0, BCD_UNITS = BCD_TENS = 0, CARRY = WRAP = ERR = 0, scan counter = 0, units selected, SEG showing "0".
REQ-027 SHALL resume sampling at first rising edge after RESET deasserts; reset mid-scan or mid-pulse SHALL truncate the pulse and restart scan at count 0.
REQ-028 SHALL not emit CARRY on first post-reset sample of bit0 (stored bit0 -> bit0 is a hold).

Verification
REQ-029 Step UNITS_OH bit0..bit9 one per cycle -> BCD_UNITS 0..9 one cycle later each, CARRY stays 0.
REQ-030 UNITS_OH bit9 then bit0 -> CARRY = 1 exactly one cycle, BCD_UNITS = 0 that cycle.
REQ-031 TENS_OH bit5->bit0 with UNITS_OH bit9->bit0 same edge -> CARRY = WRAP = 1 same cycle, both 0 next.
REQ-032 UNITS_OH = 10'b0000000101 for one cycle after bit3 -> ERR = 1 one cycle, BCD_UNITS stays 3, SEG dash; then bit4 -> ERR = 0, BCD_UNITS = 4, no CARRY.
REQ-033 SCAN_DIV = 4, SEG_ACTIVE_LOW = 1, units 7 tens 2 -> DIG alternates 2'b10/2'b01 every 4 cycles, SEG = ~7'b1011011 on tens, ~7'b0000111 on units.
REQ-034 Assert RESET asynchronously mid-CARRY and mid-scan -> all outputs reset values immediately, scan restarts at 0 after release.

Source files
------------

// File: rtl/onehot_display_driver_if.sv
// Bus between the upstream one-hot counters / display and onehot_display_driver.
//   UNITS_OH  : one-hot units digit (decade counter), synchronous to CLK
//   TENS_OH   : one-hot tens digit (mod-6 counter), synchronous to CLK
//   BCD_UNITS : registered BCD of the last valid UNITS_OH
//   BCD_TENS  : registered BCD of the last valid TENS_OH
//   CARRY     : one-cycle pulse on units 9 -> 0
//   WRAP      : one-cycle pulse on tens 5 -> 0 or 9 -> 0
//   ERR       : registered flag, an input sample was not one-hot
//   SEG       : segments {g,f,e,d,c,b,a} of the selected digit
//   DIG       : digit select, bit0 = units, bit1 = tens
interface onehot_display_driver_if;
  logic [9:0] UNITS_OH;
  logic [9:0] TENS_OH;
  logic [3:0] BCD_UNITS;
  logic [3:0] BCD_TENS;
  logic       CARRY;
  logic       WRAP;
  logic       ERR;
  logic [6:0] SEG;
  logic [1:0] DIG;

  modport master (
    output UNITS_OH, TENS_OH,
    input  BCD_UNITS, BCD_TENS, CARRY, WRAP, ERR, SEG, DIG
  );

  modport slave (
    input  UNITS_OH, TENS_OH,
    output BCD_UNITS, BCD_TENS, CARRY, WRAP, ERR, SEG, DIG
  );
endinterface

// File: rtl/onehot_display_driver.sv
// Converts the one-hot units/tens digits of an upstream counter into BCD,
// flags carry/wrap edges and invalid samples, and multiplexes both digits
// onto one 7-segment driver.
//   CLK   : single clock, rising edge
//   RESET : asynchronous, active-high
//   bus   : onehot_display_driver_if slave (one-hot inputs, BCD, pulses, SEG/DIG)
// Parameters:
//   SCAN_DIV       : cycles each digit stays selected (2..1024)
//   SEG_ACTIVE_LOW : 1 = SEG/DIG driven active-low at the pins
//
// Digit-select states
//   state     | meaning
//   DIG_UNITS | units digit driven onto SEG, DIG bit0 active
//   DIG_TENS  | tens digit driven onto SEG, DIG bit1 active
module onehot_display_driver #(
  parameter int SCAN_DIV       = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic                     CLK,
  input logic                     RESET,
  onehot_display_driver_if.slave  bus
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  localparam logic DIG_UNITS = 1'b0;
  localparam logic DIG_TENS  = 1'b1;

  localparam logic [6:0] SEG_DASH = 7'b1000000;

  logic [9:0]    units_q;
  logic [9:0]    tens_q;
  logic [3:0]    bcd_units_q;
  logic [3:0]    bcd_tens_q;
  logic          carry_q;
  logic          wrap_q;
  logic          err_q;
  logic [CW-1:0] scan_cnt_q;
  logic          dig_state_q;

  logic          units_ok;
  logic          tens_ok;
  logic [3:0]    sel_bcd;
  logic [6:0]    seg_int;
  logic [1:0]    dig_int;

  function automatic logic is_onehot(input logic [9:0] v);
    // clearing the lowest set bit leaves zero only when exactly one bit was set
    return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
  endfunction

  function automatic logic [3:0] oh_to_bcd(input logic [9:0] oh);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (oh[i]) r = 4'(i);
    end
    return r;
  endfunction

  assign units_ok = is_onehot(bus.UNITS_OH);
  assign tens_ok  = is_onehot(bus.TENS_OH);

  // Edges are judged against the last valid stored one-hot, so an invalid
  // sample in between neither fires a pulse nor disturbs the history.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      units_q     <= 10'd1;
      tens_q      <= 10'd1;
      bcd_units_q <= 4'd0;
      bcd_tens_q  <= 4'd0;
      carry_q     <= 1'b0;
      wrap_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q   <= !units_ok || !tens_ok;
      carry_q <= units_ok && units_q[9] && bus.UNITS_OH[0];
      wrap_q  <= tens_ok && (tens_q[5] || tens_q[9]) && bus.TENS_OH[0];
      if (units_ok) begin
        units_q     <= bus.UNITS_OH;
        bcd_units_q <= oh_to_bcd(bus.UNITS_OH);
      end
      if (tens_ok) begin
        tens_q     <= bus.TENS_OH;
        bcd_tens_q <= oh_to_bcd(bus.TENS_OH);
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      scan_cnt_q  <= '0;
      dig_state_q <= DIG_UNITS;
    end else if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_q  <= '0;
      dig_state_q <= (dig_state_q == DIG_UNITS) ? DIG_TENS : DIG_UNITS;
    end else begin
      scan_cnt_q  <= scan_cnt_q + 1'b1;
    end
  end

  assign sel_bcd = (dig_state_q == DIG_TENS) ? bcd_tens_q : bcd_units_q;
  assign dig_int = (dig_state_q == DIG_TENS) ? 2'b10 : 2'b01;

  // segment order {g,f,e,d,c,b,a}
  always_comb begin
    seg_int = 7'b0000000;
    if (err_q) begin
      seg_int = SEG_DASH;
    end else begin
      case (sel_bcd)
        4'd0:    seg_int = 7'b0111111;
        4'd1:    seg_int = 7'b0000110;
        4'd2:    seg_int = 7'b1011011;
        4'd3:    seg_int = 7'b1001111;
        4'd4:    seg_int = 7'b1100110;
        4'd5:    seg_int = 7'b1101101;
        4'd6:    seg_int = 7'b1111101;
        4'd7:    seg_int = 7'b0000111;
        4'd8:    seg_int = 7'b1111111;
        4'd9:    seg_int = 7'b1101111;
        default: seg_int = 7'b0000000;
      endcase
    end
  end

  assign bus.BCD_UNITS = bcd_units_q;
  assign bus.BCD_TENS  = bcd_tens_q;
  assign bus.CARRY     = carry_q;
  assign bus.WRAP      = wrap_q;
  assign bus.ERR       = err_q;
  assign bus.SEG       = SEG_ACTIVE_LOW ? ~seg_int : seg_int;
  assign bus.DIG       = SEG_ACTIVE_LOW ? ~dig_int : dig_int;

endmodule

// File: tb/tb_onehot_display_driver.sv
module tb_onehot_display_driver;
  localparam int SCAN_DIV = 4;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  onehot_display_driver_if bus();

  onehot_display_driver #(.SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  // rising edges seen since reset released; selects which digit is expected
  int n_edges = 0;
  always @(posedge CLK or posedge RESET) begin
    if (RESET) n_edges <= 0;
    else       n_edges <= n_edges + 1;
  end

  int checks = 0;
  int fails  = 0;

  // reference model: stored digits as integers, expected registered flags
  int m_u = 0;
  int m_t = 0;
  bit e_carry = 1'b0;
  bit e_wrap  = 1'b0;
  bit e_err   = 1'b0;

  // {g,f,e,d,c,b,a} for 0..9
  logic [6:0] digit_seg [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // reset pin pattern: BCD 0/0, no flags, "0" active-low, units active-low
  localparam logic [19:0] RESET_PINS = {4'd0, 4'd0, 3'b000, 7'b1000000, 2'b10};

  function automatic logic [9:0] oh(input int k);
    logic [9:0] one;
    one = 10'd1;
    return one << k;
  endfunction

  function automatic int oh_idx(input logic [9:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < 10; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [19:0] expected();
    bit         tens_sel;
    logic [6:0] seg;
    logic [1:0] dig;
    tens_sel = ((n_edges / SCAN_DIV) % 2) == 1;
    seg = e_err ? 7'h40 : digit_seg[tens_sel ? m_t : m_u];
    dig = tens_sel ? 2'b10 : 2'b01;
    return {4'(m_u), 4'(m_t), e_carry, e_wrap, e_err, ~seg, ~dig};
  endfunction

  function automatic logic [19:0] observed();
    return {bus.BCD_UNITS, bus.BCD_TENS, bus.CARRY, bus.WRAP, bus.ERR, bus.SEG, bus.DIG};
  endfunction

  task automatic model_reset();
    m_u = 0; m_t = 0;
    e_carry = 1'b0; e_wrap = 1'b0; e_err = 1'b0;
  endtask

  // drive one sample, advance one edge, update the model, settle 1 time unit
  task automatic cycle(input logic [9:0] u, input logic [9:0] t);
    int iu, it;
    bus.UNITS_OH = u;
    bus.TENS_OH  = t;
    @(posedge CLK);
    iu = oh_idx(u);
    it = oh_idx(t);
    e_err   = (iu < 0) || (it < 0);
    e_carry = (iu == 0) && (m_u == 9);
    e_wrap  = (it == 0) && ((m_t == 5) || (m_t == 9));
    if (iu >= 0) m_u = iu;
    if (it >= 0) m_t = it;
    #1;
  endtask

  task automatic test_reset();
    bus.UNITS_OH = oh(0);
    bus.TENS_OH  = oh(0);
    model_reset();
    #1;
    checks++;
    if (observed() !== RESET_PINS) begin
      fails++; $display("FAIL reset_t0: got %h expected %h", observed(), RESET_PINS);
    end
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (observed() !== RESET_PINS) begin
      fails++; $display("FAIL reset_held: got %h expected %h", observed(), RESET_PINS);
    end
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_units_step();
    for (int k = 0; k < 10; k++) begin
      cycle(oh(k), oh(0));
      checks++;
      if (observed() !== expected() || bus.BCD_UNITS !== 4'(k) || bus.CARRY !== 1'b0) begin
        fails++; $display("FAIL units_step%0d: got %h expected %h", k, observed(), expected());
      end
    end
  endtask

  task automatic test_carry();
    cycle(oh(0), oh(0));
    checks++;
    if (bus.CARRY !== 1'b1 || bus.BCD_UNITS !== 4'd0 || observed() !== expected()) begin
      fails++; $display("FAIL carry_pulse: got %h expected %h", observed(), expected());
    end
    cycle(oh(1), oh(0));
    checks++;
    if (bus.CARRY !== 1'b0 || observed() !== expected()) begin
      fails++; $display("FAIL carry_end: got %h expected %h", observed(), expected());
    end
  endtask

  task automatic test_carry_wrap();
    cycle(oh(9), oh(5));
    cycle(oh(0), oh(0));
    checks++;
    if ({bus.CARRY, bus.WRAP} !== 2'b11 || observed() !== expected()) begin
      fails++; $display("FAIL carry_wrap_both: got %h expected %h", observed(), expected());
    end
    cycle(oh(0), oh(0));
    checks++;
    if ({bus.CARRY, bus.WRAP} !== 2'b00 || observed() !== expected()) begin
      fails++; $display("FAIL carry_wrap_hold: got %h expected %h", observed(), expected());
    end
  endtask

  task automatic test_err();
    cycle(oh(3), oh(0));
    cycle(10'b0000000101, oh(0));
    checks++;
    if (bus.ERR !== 1'b1 || bus.BCD_UNITS !== 4'd3 || bus.SEG !== ~7'b1000000
        || observed() !== expected()) begin
      fails++; $display("FAIL err_flag: got %h expected %h", observed(), expected());
    end
    cycle(oh(4), oh(0));
    checks++;
    if (bus.ERR !== 1'b0 || bus.BCD_UNITS !== 4'd4 || bus.CARRY !== 1'b0
        || observed() !== expected()) begin
      fails++; $display("FAIL err_recover: got %h expected %h", observed(), expected());
    end
  endtask

  task automatic test_scan();
    for (int i = 0; i < 20; i++) begin
      cycle(oh(7), oh(2));
      checks++;
      if (observed() !== expected() || !(bus.DIG == 2'b01 || bus.DIG == 2'b10)) begin
        fails++; $display("FAIL scan%0d: got %h expected %h", i, observed(), expected());
      end
    end
  endtask

  task automatic test_random();
    int r;
    logic [9:0] u, t;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 50)      u = oh((m_u + 1) % 10);
      else if (r < 85) u = oh($urandom_range(0, 9));
      else begin
        u = 10'($urandom);
        if ($countones(u) == 1) u = 10'd0;
      end
      r = $urandom_range(0, 99);
      if (r < 40)      t = oh((m_t >= 5) ? 0 : m_t + 1);
      else if (r < 55) t = oh((m_t == 9) ? 0 : 9);
      else if (r < 85) t = oh($urandom_range(0, 9));
      else begin
        t = 10'($urandom);
        if ($countones(t) == 1) t = 10'b1100000000;
      end
      cycle(u, t);
      checks++;
      if (observed() !== expected()) begin
        fails++; $display("FAIL random%0d: got %h expected %h", i, observed(), expected());
      end
    end
  endtask

  task automatic test_async_reset();
    cycle(oh(9), oh(5));
    cycle(oh(0), oh(0));
    #2;
    RESET = 1'b1;
    model_reset();
    #1;
    checks++;
    if (observed() !== RESET_PINS) begin
      fails++; $display("FAIL async_reset: got %h expected %h", observed(), RESET_PINS);
    end
    #3;
    RESET = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cycle(oh(0), oh(0));
      checks++;
      if (observed() !== expected()) begin
        fails++; $display("FAIL post_reset%0d: got %h expected %h", i, observed(), expected());
      end
      if (i == 3 || i == 4) begin
        checks++;
        if (bus.DIG !== ((i == 3) ? 2'b10 : 2'b01) || bus.CARRY !== 1'b0) begin
          fails++; $display("FAIL scan_restart%0d: got %b expected %b", i, bus.DIG,
                            (i == 3) ? 2'b10 : 2'b01);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_units_step();
    test_carry();
    test_carry_wrap();
    test_err();
    test_scan();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
